// File: rtl/pipelined_calculator.sv
// pipelined_calculator: register-file ALU with valid/ready command/result handshakes and a WIDTH-step shift-add multiplier
module pipelined_calculator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic [3:0]               Ctrl,
  input  logic                     Sel,
  input  logic [$clog2(DEPTH)-1:0] RX,
  input  logic [$clog2(DEPTH)-1:0] RY,
  input  logic [$clog2(DEPTH)-1:0] RW,
  input  logic                     WEN,
  input  logic [WIDTH-1:0]         DataIn,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [WIDTH-1:0]         Result,
  output logic                     Carry
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic IDLE = 1'b0;
  localparam logic MUL = 1'b1;
  localparam logic [3:0] OP_MUL = 4'b1101;
  logic state_q, state_d;
  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic carry_q, carry_d;
  logic [WIDTH-1:0] rf_q [DEPTH];
  logic [WIDTH-1:0] rf_d [DEPTH];
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wen_q, wen_d;
  logic [AW-1:0] rw_q, rw_d;
  logic [WIDTH-1:0] a, b, alu_r;
  logic alu_c;
  logic [SW-1:0] sh;
  logic [WIDTH:0] sum;
  logic accept, mul_done;
  assign In_ready = Rst_n && (state_q == IDLE) && (!out_valid_q || Out_ready);
  assign accept = In_valid && In_ready;
  assign a = Sel ? rf_q[RX] : DataIn;
  assign b = rf_q[RY];
  assign sh = b[SW-1:0];
  assign sum = {1'b0, a} + {1'b0, b};
  assign mul_done = (state_q == MUL) && (cnt_q == CW'(WIDTH));
  assign Out_valid = out_valid_q;
  assign Result = result_q;
  assign Carry = carry_q;
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (Ctrl)
      4'b0000: {alu_c, alu_r} = sum;
      4'b0001: begin
        alu_r = a - b;
        alu_c = a < b;
      end
      4'b0010: alu_r = a & b;
      4'b0011: alu_r = a | b;
      4'b0100: alu_r = a ^ b;
      4'b0101: alu_r = ~(a | b);
      4'b0110: alu_r = ~a;
      4'b0111: alu_r = a << sh;
      4'b1000: alu_r = a >> sh;
      4'b1001: alu_r = $unsigned($signed(a) >>> sh);
      4'b1010: alu_r = (a << sh) | (a >> (WIDTH - int'(sh)));
      4'b1011: alu_r = (a >> sh) | (a << (WIDTH - int'(sh)));
      4'b1100: alu_r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1110: alu_r = a;
      4'b1111: alu_c = a == b;
      default: ;
    endcase
  end
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q && !Out_ready;
    result_d = result_q;
    carry_d = carry_q;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    wen_d = wen_q;
    rw_d = rw_q;
    rf_d = rf_q;
    if (accept) begin
      wen_d = WEN;
      rw_d = RW;
      if (Ctrl == OP_MUL) begin
        state_d = MUL;
        cnt_d = '0;
        acc_d = '0;
        mcand_d = {{WIDTH{1'b0}}, a};
        mplier_d = b;
      end else begin
        out_valid_d = 1'b1;
        result_d = alu_r;
        carry_d = alu_c;
        if (WEN) rf_d[RW] = alu_r;
      end
    end else if (mul_done) begin
      state_d = IDLE;
      out_valid_d = 1'b1;
      result_d = acc_q[WIDTH-1:0];
      carry_d = |acc_q[2*WIDTH-1:WIDTH];
      if (wen_q) rf_d[rw_q] = acc_q[WIDTH-1:0];
    end else if (state_q == MUL) begin
      acc_d = mplier_q[0] ? acc_q + mcand_q : acc_q;
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
    rf_d[0] = '0;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      carry_q <= 1'b0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      wen_q <= 1'b0;
      rw_q <= '0;
      rf_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      carry_q <= carry_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      wen_q <= wen_d;
      rw_q <= rw_d;
      rf_q <= rf_d;
    end
  end
endmodule

// File: tb/tb_pipelined_calculator.sv
// tb_pipelined_calculator: scoreboard bench for pipelined_calculator with directed and random traffic
module tb_pipelined_calculator;
  logic Clk = 0, Rst_n = 0, In_valid = 0, Sel = 0, WEN = 0, Out_ready = 1;
  logic In_ready, Out_valid, Carry;
  logic [3:0] Ctrl = 0;
  logic [2:0] RX = 0, RY = 0, RW = 0;
  logic [7:0] DataIn = 0, Result;
  logic [7:0] mrf [8];
  logic [8:0] sb [$];
  int checks = 0, errors = 0;
  bit rand_bp = 0;
  always #5 Clk = ~Clk;
  pipelined_calculator dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready), .Ctrl(Ctrl), .Sel(Sel),
    .RX(RX), .RY(RY), .RW(RW), .WEN(WEN), .DataIn(DataIn), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Result(Result), .Carry(Carry)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic c;
    logic [15:0] p;
    int s, sa, sb_;
    r = 0;
    c = 0;
    s = int'(b[2:0]);
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb_ = b[7] ? int'(b) - 256 : int'(b);
    case (op)
      4'h0: begin p = 16'(a) + 16'(b); r = p[7:0]; c = p[8]; end
      4'h1: begin r = a - b; c = a < b; end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~(a | b);
      4'h6: r = ~a;
      4'h7: r = a << s;
      4'h8: r = a >> s;
      4'h9: begin r = a; repeat (s) r = {r[7], r[7:1]}; end
      4'hA: begin r = a; repeat (s) r = {r[6:0], r[7]}; end
      4'hB: begin r = a; repeat (s) r = {r[0], r[7:1]}; end
      4'hC: r = {7'd0, sa < sb_};
      4'hD: begin p = 16'(a) * 16'(b); r = p[7:0]; c = |p[15:8]; end
      4'hE: r = a;
      default: c = a == b;
    endcase
    return {c, r};
  endfunction
  task automatic drive(input int op, input int s, input int x, input int y, input int w, input int we,
                       input int d, output logic [8:0] e);
    logic [7:0] a;
    Ctrl = 4'(op); Sel = 1'(s); RX = 3'(x); RY = 3'(y); RW = 3'(w); WEN = 1'(we); DataIn = 8'(d);
    In_valid = 1;
    a = Sel ? mrf[RX] : DataIn;
    e = model(Ctrl, a, mrf[RY]);
    if (WEN && RW != 0) mrf[RW] = e[7:0];
  endtask
  task automatic issue(input int op, input int s, input int x, input int y, input int w, input int we,
                       input int d, input int want = -1);
    logic [8:0] e;
    int n = 0;
    @(negedge Clk);
    drive(op, s, x, y, w, we, d, e);
    if (want >= 0) e = 9'(want);
    #1;
    while (!In_ready && n < 100) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (!In_ready) begin
      check("in_ready_timeout", 32'(In_ready), 1);
      In_valid = 0;
      return;
    end
    sb.push_back(e);
    @(posedge Clk);
    #1 In_valid = 0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge Clk);
  endtask
  task automatic do_reset(input int cycles);
    @(negedge Clk);
    Rst_n = 0;
    In_valid = 0;
    sb.delete();
    foreach (mrf[i]) mrf[i] = 0;
    repeat (cycles) @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(Out_valid), 0);
    check("rst_result", 32'(Result), 0);
    check("rst_carry", 32'(Carry), 0);
    check("rst_in_ready", 32'(In_ready), 0);
    @(negedge Clk);
    Rst_n = 1;
  endtask
  always begin
    @(negedge Clk);
    #1;
    if (Rst_n && Out_valid && Out_ready) begin
      if (sb.size() == 0) check("unexpected_out", sb.size(), 1);
      else check("result", 32'({Carry, Result}), 32'(sb.pop_front()));
    end
  end
  always @(negedge Clk) if (rand_bp) Out_ready = ($urandom_range(0, 3) != 0);
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    bit busy_ok, seen;
    logic [8:0] e, ea;
    foreach (mrf[i]) mrf[i] = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1;
    for (int k = 1; k < 8; k++) issue(4'hE, 0, 0, 0, k, 1, k * 8'h11);
    issue(4'hE, 1, 3, 0, 0, 0, 0, 9'h033);
    wait_drain();
    do_reset(4);
    for (int k = 0; k < 8; k++) issue(4'hE, 1, k, 0, 0, 0, 8'hFF, 0);
    issue(4'hE, 0, 0, 0, 1, 1, 8'hF0, 9'h0F0);
    issue(4'hE, 0, 0, 0, 2, 1, 8'h20, 9'h020);
    issue(4'h0, 1, 1, 2, 3, 1, 0, 9'h110);
    issue(4'h1, 1, 2, 1, 0, 0, 0, 9'h130);
    issue(4'h1, 1, 1, 2, 0, 0, 0, 9'h0D0);
    issue(4'hE, 1, 3, 0, 0, 0, 0, 9'h010);
    issue(4'hE, 0, 0, 0, 1, 1, 8'h12);
    issue(4'hE, 0, 0, 0, 2, 1, 8'h34);
    issue(4'hD, 1, 1, 2, 3, 1, 0, 9'h1A8);
    n = 0;
    busy_ok = 1;
    do begin
      @(posedge Clk);
      #1;
      n++;
      if (!Out_valid && In_ready) busy_ok = 0;
    end while (!Out_valid && n < 20);
    check("mul_latency", n, 9);
    check("mul_busy_in_ready", 32'(busy_ok), 1);
    issue(4'hE, 1, 3, 0, 0, 0, 0, 9'h0A8);
    issue(4'h0, 1, 1, 2, 4, 1, 0, 9'h046);
    issue(4'hE, 1, 4, 0, 0, 0, 0, 9'h046);
    issue(4'hE, 0, 0, 0, 0, 1, 8'h55, 9'h055);
    issue(4'hE, 1, 0, 0, 0, 0, 0, 0);
    wait_drain();
    @(negedge Clk);
    Out_ready = 0;
    issue(4'h0, 1, 1, 2, 0, 0, 0, 9'h046);
    ea = 9'h046;
    @(negedge Clk);
    drive(4'h4, 1, 1, 2, 6, 1, 0, e);
    #1;
    repeat (5) begin
      check("bp_in_ready", 32'(In_ready), 0);
      check("bp_result", 32'({Carry, Result}), 32'(ea));
      @(negedge Clk);
      #1;
    end
    @(negedge Clk);
    Out_ready = 1;
    #1;
    check("bp_release_ready", 32'(In_ready), 1);
    sb.push_back(e);
    @(posedge Clk);
    #1 In_valid = 0;
    check("bp_next_valid", 32'(Out_valid), 1);
    check("bp_next_result", 32'({Carry, Result}), 9'h026);
    wait_drain();
    issue(4'hD, 1, 1, 2, 5, 1, 0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 0;
    sb.delete();
    foreach (mrf[i]) mrf[i] = 0;
    @(posedge Clk);
    #1;
    check("abort_out_valid", 32'(Out_valid), 0);
    @(negedge Clk);
    Rst_n = 1;
    #1;
    check("abort_idle_ready", 32'(In_ready), 1);
    seen = 0;
    repeat (12) begin
      @(posedge Clk);
      #1;
      if (Out_valid) seen = 1;
    end
    check("abort_no_result", 32'(seen), 0);
    issue(4'hE, 1, 5, 0, 0, 0, 0, 0);
    wait_drain();
    for (int k = 1; k < 8; k++) issue(4'hE, 0, 0, 0, k, 1, $urandom_range(0, 255));
    rand_bp = 1;
    repeat (80) issue($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 255));
    rand_bp = 0;
    @(negedge Clk);
    Out_ready = 1;
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
